// File: rtl/dec5_serial.sv
// Bit-serial decrementer: o = i - 1 (mod 2^WIDTH), formed by adding all-ones
// one bit per clock through a single full-adder cell with a registered carry.
module dec5_serial #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             underflow
);

  // state | meaning
  // IDLE  | waiting for start; o/underflow hold the last result
  // SHIFT | one operand bit consumed per edge, LSB first
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] o_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             uf_q;

  logic             bit_s;
  logic             sum_d;
  logic             c_d;
  logic [WIDTH-1:0] res_d;

  // Full adder with the second operand tied to 1: carry is majority(a,1,c) = a|c.
  always_comb begin
    bit_s = a_q[0];
    sum_d = bit_s ^ 1'b1 ^ c_q;
    c_d   = bit_s | c_q;
    res_d = {sum_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      res_q   <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            a_q     <= i;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          c_q   <= c_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            o_q     <= res_d;
            uf_q    <= ~c_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o         = o_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_dec5_serial.sv
// Bench for dec5_serial: an arithmetic reference model checked every cycle,
// plus directed literal expectations and a shuffled sweep of all operands.
module tb_dec5_serial;
  localparam int W = 5;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] i = '0;
  logic [W-1:0] o;
  logic         busy, done, underflow;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  dec5_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .i(i),
    .o(o), .busy(busy), .done(done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation occupies W edges after acceptance.
  int           rem = 0;
  int           m_op = 0;
  int           m_o = 0;
  bit           m_uf = 1'b0;
  bit           m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rem = 0; m_o = 0; m_uf = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          m_op = int'(i);
          rem  = W;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          m_o    = (m_op - 1) & MASK;
          m_uf   = (m_op == 0);
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("o", 32'(o), 32'(m_o));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'(rem > 0 && rem < W));
    end
  end

  // Caller is at a negedge. Returns negedges until done and busy cycles seen.
  task automatic op(input int v, input bit stray, output int lat, output int nb);
    start = 1'b1;
    i = W'(v);
    lat = 0;
    nb = 0;
    while (lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (done) begin
        start = 1'b0;
        break;
      end
      start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      i = W'($urandom);
    end
    check("op_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input string name, input int v, input int exp_o, input bit exp_uf);
    int lat, nb;
    op(v, 1'b0, lat, nb);
    check({name, "_o"}, 32'(o), 32'(exp_o));
    check({name, "_uf"}, 32'(underflow), 32'(exp_uf));
    check({name, "_model_o"}, 32'(m_o), 32'(exp_o));
  endtask

  initial begin
    int lat, nb, cnt;
    int perm[32];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_o", 32'(o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    repeat (10) @(negedge clk);
    check("idle_o", 32'(o), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    op(17, 1'b0, lat, nb);
    check("i17_latency", 32'(lat - 1), 32'(W));
    check("i17_busy_cycles", 32'(nb), 32'(W - 1));
    check("i17_o", 32'(o), 32'd16);
    check("i17_uf", 32'(underflow), 32'd0);
    @(negedge clk);
    check("i17_done_pulse", 32'(done), 32'd0);

    run_op("i16", 16, 15, 1'b0);
    run_op("i1", 1, 0, 1'b0);
    run_op("i31", 31, 30, 1'b0);
    run_op("i0", 0, 31, 1'b1);
    run_op("i2", 2, 1, 1'b0);

    // start while busy is ignored
    start = 1'b1; i = W'(20);
    @(negedge clk); start = 1'b0; i = '0;
    @(negedge clk); start = 1'b1; i = W'(9);
    @(negedge clk); start = 1'b0; i = '0;
    cnt = 0;
    while (!done && cnt < 4 * W) begin @(negedge clk); cnt++; end
    check("midop_done_seen", 32'(done), 32'd1);
    check("midop_o", 32'(o), 32'd19);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (done) cnt++; end
    check("midop_extra_done", 32'(cnt), 32'd0);

    // back-to-back: second start issued in the done cycle
    op(20, 1'b0, lat, nb);
    check("b2b_first_o", 32'(o), 32'd19);
    op(9, 1'b0, lat, nb);
    check("b2b_latency", 32'(lat - 1), 32'(W));
    check("b2b_o", 32'(o), 32'd8);

    // reset during an operation
    repeat (2) @(negedge clk);
    start = 1'b1; i = W'(12);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (10) begin if (done) cnt++; @(negedge clk); end
    check("rstmid_no_done", 32'(cnt), 32'd0);
    check("rstmid_o", 32'(o), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    run_op("after_rst", 12, 11, 1'b0);

    // shuffled sweep of every operand with stray starts while busy
    for (int k = 0; k < 32; k++) perm[k] = k;
    for (int k = 31; k > 0; k--) begin
      int j, t;
      j = $urandom_range(0, k);
      t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 32; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(perm[k], 1'b1, lat, nb);
      check("sweep_o", 32'(o), 32'((perm[k] - 1) & MASK));
      check("sweep_uf", 32'(underflow), 32'(perm[k] == 0));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
